// File: rtl/mode_ctrl_pkg.sv
// Purpose: shared defaults, legal index limits and index-pair type for mode_ctrl.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mode_ctrl_pkg;

  localparam int DEF_N_CH    = 2;    // path 0 = TX, path 1 = RX
  localparam int DEF_M_W     = 3;    // modulation index width
  localparam int DEF_SS_W    = 4;    // spreading index width
  localparam int DEF_M       = 1;    // post-reset modulation index
  localparam int DEF_SS      = 1;    // post-reset spreading index
  localparam int MAX_M       = 5;    // highest legal modulation index
  localparam int MAX_SS      = 15;   // highest legal spreading index
  localparam int DEF_RST_DLY = 100;  // cycles from reset release to del_rst

  // One path's active or staged setting.
  typedef struct packed {
    logic [DEF_M_W-1:0]  m;
    logic [DEF_SS_W-1:0] ss;
  } idx_pair_t;

  // Range check done in 32 bits so it stays valid for any index width,
  // including widths where the limit equals the all-ones value.
  function automatic logic idx_ok(input int unsigned v, input int unsigned max_v);
    return v <= max_v;
  endfunction

endpackage

// File: rtl/mode_ctrl_if.sv
// Purpose: configuration handshake, frame strobes and per-path index outputs of mode_ctrl.
// Latency: n/a (wiring only).
// Backpressure: cfg_valid/cfg_ready; the slave holds cfg_ready low while a targeted path is pending.
// Ports: master drives cfg_*, sof, soft_rst; slave drives cfg_ready, m_out, ss_out, upd, pend,
//        cfg_err, del_rst.
interface mode_ctrl_if
  import mode_ctrl_pkg::*;
#(
  parameter int N_CH = DEF_N_CH,
  parameter int M_W  = DEF_M_W,
  parameter int SS_W = DEF_SS_W
) ();

  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [M_W-1:0]       cfg_m;
  logic [SS_W-1:0]      cfg_ss;
  logic [N_CH-1:0]      cfg_ch_mask;
  logic [N_CH-1:0]      sof;
  logic [N_CH*M_W-1:0]  m_out;
  logic [N_CH*SS_W-1:0] ss_out;
  logic [N_CH-1:0]      upd;
  logic [N_CH-1:0]      pend;
  logic                 cfg_err;
  logic                 soft_rst;
  logic                 del_rst;

  modport master (
    output cfg_valid, cfg_m, cfg_ss, cfg_ch_mask, sof, soft_rst,
    input  cfg_ready, m_out, ss_out, upd, pend, cfg_err, del_rst
  );

  modport slave (
    input  cfg_valid, cfg_m, cfg_ss, cfg_ch_mask, sof, soft_rst,
    output cfg_ready, m_out, ss_out, upd, pend, cfg_err, del_rst
  );

endinterface

// File: rtl/mode_ctrl_rst_delay.sv
// Purpose: saturating post-reset delay counter; del_rst goes high RST_DLY+1 edges after release.
// Latency: del_rst rises one edge after the count reaches RST_DLY; soft_rst clears on the next edge.
// Backpressure: none.
// Ports: clk, rst_n (async, active-low), soft_rst (sync counter restart), del_rst (out).
module rst_delay
  import mode_ctrl_pkg::*;
#(
  parameter int RST_DLY = DEF_RST_DLY  // legal 1..65535
) (
  input  logic clk,
  input  logic rst_n,
  input  logic soft_rst,
  output logic del_rst
);

  localparam int CW = $clog2(RST_DLY + 1);
  localparam logic [CW-1:0] LIM = CW'(RST_DLY);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      del_rst <= 1'b0;
    end else if (soft_rst) begin
      cnt     <= '0;
      del_rst <= 1'b0;
    end else begin
      if (cnt != LIM) begin
        cnt <= cnt + 1'b1;
      end
      // Registered off the saturated count, so it rises one edge after
      // the count first equals the limit and then holds.
      if (cnt == LIM) begin
        del_rst <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/mode_ctrl.sv
// Purpose: per-path modulation/spreading index control with staged updates committed on sof.
// Latency: request staged one edge after acceptance; staged value goes live one edge after sof.
// Backpressure: cfg_ready drops while any path in cfg_ch_mask still holds an uncommitted stage.
// Ports: clk, rst_n (async, active-low), bus (mode_ctrl_if.slave: cfg handshake, sof, soft_rst,
//        m_out/ss_out/upd/pend/cfg_err/del_rst).
module mode_ctrl
  import mode_ctrl_pkg::*;
#(
  parameter int N_CH    = DEF_N_CH,
  parameter int M_W     = DEF_M_W,
  parameter int SS_W    = DEF_SS_W,
  parameter int M_DEF   = DEF_M,
  parameter int SS_DEF  = DEF_SS,
  parameter int M_MAX   = MAX_M,
  parameter int SS_MAX  = MAX_SS,
  parameter int RST_DLY = DEF_RST_DLY
) (
  input logic        clk,
  input logic        rst_n,
  mode_ctrl_if.slave bus
);

  localparam logic [N_CH*M_W-1:0]  M_RST  = {N_CH{M_W'(M_DEF)}};
  localparam logic [N_CH*SS_W-1:0] SS_RST = {N_CH{SS_W'(SS_DEF)}};

  logic [N_CH*M_W-1:0]  m_act;
  logic [N_CH*SS_W-1:0] ss_act;
  logic [N_CH*M_W-1:0]  m_stg;
  logic [N_CH*SS_W-1:0] ss_stg;
  logic [N_CH-1:0]      pend_q;
  logic [N_CH-1:0]      upd_q;
  logic                 cfg_err_q;
  logic                 del_rst_w;

  logic                 cfg_ready_w;
  logic                 accept;
  logic                 legal;
  logic [N_CH-1:0]      commit;

  // A request may only land on paths that are free, so a stage is never
  // overwritten before it has been committed.
  assign cfg_ready_w = ~|(pend_q & bus.cfg_ch_mask);
  assign accept      = bus.cfg_valid & cfg_ready_w;
  assign legal       = idx_ok(int'(bus.cfg_m), M_MAX) &&
                       idx_ok(int'(bus.cfg_ss), SS_MAX) &&
                       (|bus.cfg_ch_mask);

  // Only already-pending paths commit; a request accepted alongside sof
  // finds pend low and therefore waits for the following sof.
  assign commit = bus.sof & pend_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act     <= M_RST;
      ss_act    <= SS_RST;
      m_stg     <= M_RST;
      ss_stg    <= SS_RST;
      pend_q    <= '0;
      upd_q     <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= accept & ~legal;
      upd_q     <= commit;
      for (int i = 0; i < N_CH; i++) begin
        if (commit[i]) begin
          m_act[i*M_W +: M_W]    <= m_stg[i*M_W +: M_W];
          ss_act[i*SS_W +: SS_W] <= ss_stg[i*SS_W +: SS_W];
          pend_q[i]              <= 1'b0;
        end else if (accept && legal && bus.cfg_ch_mask[i]) begin
          // Acceptance implies pend_q[i] was clear, so this never races a commit.
          m_stg[i*M_W +: M_W]    <= bus.cfg_m;
          ss_stg[i*SS_W +: SS_W] <= bus.cfg_ss;
          pend_q[i]              <= 1'b1;
        end
      end
    end
  end

  rst_delay #(
    .RST_DLY (RST_DLY)
  ) u_rst_delay (
    .clk      (clk),
    .rst_n    (rst_n),
    .soft_rst (bus.soft_rst),
    .del_rst  (del_rst_w)
  );

  assign bus.cfg_ready = cfg_ready_w;
  assign bus.m_out     = m_act;
  assign bus.ss_out    = ss_act;
  assign bus.upd       = upd_q;
  assign bus.pend      = pend_q;
  assign bus.cfg_err   = cfg_err_q;
  assign bus.del_rst   = del_rst_w;

endmodule
